// File: rtl/div_unit_param.sv
// Parametrised restoring radix-2 integer divider, one quotient bit per clock.
// Quotient is returned on lo and remainder on hi, with signed/unsigned mode per operation.
module div_unit_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sinalStartDiv,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             sinalParadaDiv,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   count_r;
    logic [WIDTH-1:0]   dvd_r;
    logic [WIDTH-1:0]   dvs_r;
    logic [WIDTH-1:0]   rem_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;
    logic               dz_r;

    logic [WIDTH:0]     r_shift_s;
    logic               q_bit_s;
    logic [WIDTH-1:0]   r_diff_s;

    // Two's-complement negation when requested; MIN maps to itself as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] res;
        if (neg) begin
            res = ~v + WIDTH'(1);
        end else begin
            res = v;
        end
        return res;
    endfunction

    // One restoring step: the WIDTH+1 bit compare cannot overflow, and the
    // difference always fits in WIDTH bits because it is below the divisor.
    always_comb begin
        r_shift_s = {rem_r, dvd_r[WIDTH-1]};
        q_bit_s   = (r_shift_s >= {1'b0, dvs_r});
        r_diff_s  = r_shift_s[WIDTH-1:0] - dvs_r;
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            count_r <= {CNT_W{1'b0}};
            dvd_r   <= {WIDTH{1'b0}};
            dvs_r   <= {WIDTH{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (sinalStartDiv) begin
                        neg_q_r <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_r <= is_signed & a[WIDTH-1];
                        dvs_r   <= cond_neg(is_signed & b[WIDTH-1], b);
                        rem_r   <= {WIDTH{1'b0}};
                        dz_r    <= 1'b0;
                        busy_r  <= 1'b1;
                        // The zero path reports the untouched dividend, so keep the raw value.
                        if (b == {WIDTH{1'b0}}) begin
                            dvd_r   <= a;
                            state_r <= ZERO;
                        end else begin
                            dvd_r   <= cond_neg(is_signed & a[WIDTH-1], a);
                            count_r <= CNT_W'(WIDTH);
                            state_r <= ITER;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ITER: begin
                    rem_r   <= q_bit_s ? r_diff_s : r_shift_s[WIDTH-1:0];
                    dvd_r   <= {dvd_r[WIDTH-2:0], q_bit_s};
                    count_r <= count_r - CNT_W'(1);
                    if (count_r == CNT_W'(1)) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= ITER;
                    end
                end
                FIX: begin
                    lo_r    <= cond_neg(neg_q_r, dvd_r);
                    hi_r    <= cond_neg(neg_r_r, rem_r);
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                ZERO: begin
                    lo_r    <= {WIDTH{1'b1}};
                    hi_r    <= dvd_r;
                    dz_r    <= 1'b1;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign hi             = hi_r;
    assign lo             = lo_r;
    assign busy           = busy_r;
    assign sinalParadaDiv = done_r;
    assign div_by_zero    = dz_r;

endmodule

// File: tb/tb_div_unit_param.sv
// Self-checking bench for div_unit_param: arithmetic reference model checked every cycle
// on the 32-bit instance, plus directed vectors with hand-computed results.
module tb_div_unit_param;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        dz;

    logic        start8;
    logic        sgn8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;
    logic        busy8;
    logic        done8;
    logic        dz8;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic        m_busy;
    int          m_left;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_dz;
    logic        m_done;
    logic [31:0] p_lo;
    logic [31:0] p_hi;
    logic        p_z;

    div_unit_param #(.WIDTH(32), .CNT_W(6)) dut (
        .clock(clk), .reset_n(reset_n), .sinalStartDiv(start), .is_signed(sgn),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy),
        .sinalParadaDiv(done), .div_by_zero(dz)
    );

    div_unit_param #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clock(clk), .reset_n(reset_n), .sinalStartDiv(start8), .is_signed(sgn8),
        .a(a8), .b(b8), .hi(hi8), .lo(lo8), .busy(busy8),
        .sinalParadaDiv(done8), .div_by_zero(dz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", nm, $time, act, exp);
        end
    endtask

    // Plain arithmetic: 64-bit division truncates toward zero, % keeps dividend sign.
    function automatic void model_div(input logic s, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sx;
        longint sy;
        longint lq;
        longint lr;
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = x;
            z = 1'b1;
        end else begin
            sx = s ? longint'($signed(x)) : longint'(x);
            sy = s ? longint'($signed(y)) : longint'(y);
            lq = sx / sy;
            lr = sx % sy;
            q  = lq[31:0];
            r  = lr[31:0];
            z  = 1'b0;
        end
    endfunction

    // Model: result appears WIDTH+1 edges after acceptance (1 for divide by zero).
    initial begin
        m_busy = 1'b0; m_left = 0; m_hi = 32'd0; m_lo = 32'd0; m_dz = 1'b0; m_done = 1'b0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_busy = 1'b0; m_left = 0; m_hi = 32'd0; m_lo = 32'd0; m_dz = 1'b0; m_done = 1'b0;
            end else begin
                m_done = 1'b0;
                if (!m_busy) begin
                    if (start) begin
                        model_div(sgn, a, b, p_lo, p_hi, p_z);
                        m_busy = 1'b1;
                        m_left = p_z ? 1 : 33;
                        m_dz   = 1'b0;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_lo   = p_lo;
                        m_hi   = p_hi;
                        m_dz   = p_z;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("done", {31'd0, done}, {31'd0, m_done});
            check("div_by_zero", {31'd0, dz}, {31'd0, m_dz});
            check("lo", lo, m_lo);
            check("hi", hi, m_hi);
        end
    end

    task automatic wait_done(output int cnt);
        cnt = 1;
        while (!done && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic s, input logic [31:0] aa, input logic [31:0] bb,
                          input logic [31:0] elo, input logic [31:0] ehi,
                          input logic edz, input int elat);
        int cnt;
        @(negedge clk);
        sgn = s; a = aa; b = bb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("dz_cleared_on_start", {31'd0, dz}, 32'd0);
        wait_done(cnt);
        check("latency", cnt - 1, elat);
        check("lo_literal", lo, elo);
        check("hi_literal", hi, ehi);
        check("dz_literal", {31'd0, dz}, {31'd0, edz});
    endtask

    task automatic run8(input logic s, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [7:0] elo, input logic [7:0] ehi);
        int cnt;
        @(negedge clk);
        sgn8 = s; a8 = aa; b8 = bb; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("w8_busy", {31'd0, busy8}, 32'd1);
        cnt = 1;
        while (!done8 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("w8_latency", cnt - 1, 9);
        check("w8_lo", {24'd0, lo8}, {24'd0, elo});
        check("w8_hi", {24'd0, hi8}, {24'd0, ehi});
        check("w8_dz", {31'd0, dz8}, 32'd0);
    endtask

    initial begin
        int cnt;
        int pulses;
        reset_n = 1'b0; start = 1'b0; sgn = 1'b0; a = 32'd0; b = 32'd0;
        start8 = 1'b0; sgn8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_lo", lo, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz", {31'd0, dz}, 32'd0);
        reset_n = 1'b1;

        run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        run_op(1'b1, -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
        run_op(1'b1, 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 33);
        run_op(1'b1, -32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE, 1'b0, 33);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
        run_op(1'b0, 32'hFFFF_FFF2, 32'd7, 32'h2492_4922, 32'd4, 1'b0, 33);
        run_op(1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1);
        run_op(1'b1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1, 1);
        run_op(1'b0, 32'd7, 32'd9, 32'd0, 32'd7, 1'b0, 33);

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        sgn = 1'b0; a = 32'd50; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        a = 32'd9; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cnt);
        check("ignore_lo", lo, 32'd10);
        check("ignore_hi", hi, 32'd0);
        a = 32'd9; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_busy", {31'd0, busy}, 32'd1);
        check("restart_hold_lo", lo, 32'd10);
        wait_done(cnt);
        check("restart_latency", cnt - 1, 33);
        check("restart_lo", lo, 32'd3);
        check("restart_hi", hi, 32'd0);

        // Reset in the middle of an operation.
        @(negedge clk);
        sgn = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_lo", lo, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_dz", {31'd0, dz}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("no_done_after_reset", pulses, 0);
        run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);

        run8(1'b0, 8'd100, 8'd7, 8'd14, 8'd2);
        run8(1'b1, 8'h9C, 8'd7, 8'hF2, 8'hFE);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
